mano_sequencer: RTL and testbench

MANO_SEQUENCER -- requirements
Module: mano_sequencer

---
 rtl/mano_sequencer_pkg.sv | 30 +++
 rtl/mano_sequencer_if.sv | 34 +++
 rtl/mano_mem_wait.sv | 28 ++
 rtl/mano_sequencer.sv | 129 ++++++++++++
 tb/tb_mano_sequencer.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/mano_sequencer_pkg.sv
// Shared types and constants for the Mano fetch/execute sequencer.
package mano_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALT,
        ST_ERR
    } state_e;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDA = 2'b01;
    localparam logic [1:0] OP_MVR = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    localparam int unsigned MEM_TIMEOUT_DEF = 15;

    function automatic logic is_read(input state_e s);
        return (s == ST_T1) || (s == ST_T4) || (s == ST_T6);
    endfunction

endpackage

// File: rtl/mano_sequencer_if.sv
// Control/status bundle between the sequencer and its datapath.
interface mano_sequencer_if;
    logic       start;
    logic       step_mode;
    logic       step;
    logic [1:0] ir_op;
    logic       mem_ack;
    logic       ctl_mar_pc;
    logic       ctl_mar_mbr;
    logic       ctl_pc_inc;
    logic       ctl_mem_rd;
    logic       ctl_mbr_ld;
    logic       ctl_ir_ld;
    logic       ctl_a_mbr;
    logic       ctl_a_r;
    logic [2:0] t_state;
    logic       running;
    logic       halted;
    logic       mem_err;

    modport master (
        output start, step_mode, step, ir_op, mem_ack,
        input  ctl_mar_pc, ctl_mar_mbr, ctl_pc_inc, ctl_mem_rd,
        input  ctl_mbr_ld, ctl_ir_ld, ctl_a_mbr, ctl_a_r,
        input  t_state, running, halted, mem_err
    );

    modport slave (
        input  start, step_mode, step, ir_op, mem_ack,
        output ctl_mar_pc, ctl_mar_mbr, ctl_pc_inc, ctl_mem_rd,
        output ctl_mbr_ld, ctl_ir_ld, ctl_a_mbr, ctl_a_r,
        output t_state, running, halted, mem_err
    );
endinterface

// File: rtl/mano_mem_wait.sv
// Memory read wait counter; flags completion or timeout of a read step.
module mano_mem_wait
    import mano_sequencer_pkg::*;
#(
    parameter int unsigned TMO = MEM_TIMEOUT_DEF
) (
    input  logic SysClk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_ack,
    output logic done,
    output logic timeout
);
    logic [3:0] r_cnt;

    // Idle between reads keeps the count at zero for the next read step.
    always_ff @(posedge SysClk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= 4'd0;
        else if (!i_active || i_ack)
            r_cnt <= 4'd0;
        else
            r_cnt <= r_cnt + 4'd1;
    end

    assign done    = i_active & i_ack;
    assign timeout = i_active & ~i_ack & (r_cnt == 4'(TMO - 1));
endmodule

// File: rtl/mano_sequencer.sv
// Mano-style T-state sequencer: fetch, NOP/MVR/LDA/HLT execute, step mode.
module mano_sequencer
    import mano_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic               SysClk,
    input  logic               rst_n,
    mano_sequencer_if.slave    bus
);
    state_e r_state;
    state_e w_next;
    state_e w_end;
    logic   w_wait;
    logic   w_done;
    logic   w_tmo;

    assign w_wait = is_read(r_state);
    assign w_end  = bus.step_mode ? ST_PAUSE : ST_T0;

    mano_mem_wait #(.TMO(MEM_TIMEOUT)) u_wait (
        .SysClk  (SysClk),
        .rst_n   (rst_n),
        .i_active(w_wait),
        .i_ack   (bus.mem_ack),
        .done    (w_done),
        .timeout (w_tmo)
    );

    always_ff @(posedge SysClk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        bus.ctl_mar_pc  = 1'b0;
        bus.ctl_mar_mbr = 1'b0;
        bus.ctl_pc_inc  = 1'b0;
        bus.ctl_mem_rd  = 1'b0;
        bus.ctl_mbr_ld  = 1'b0;
        bus.ctl_ir_ld   = 1'b0;
        bus.ctl_a_mbr   = 1'b0;
        bus.ctl_a_r     = 1'b0;
        bus.t_state     = 3'd0;
        bus.running     = 1'b0;
        bus.halted      = 1'b0;
        bus.mem_err     = 1'b0;
        unique case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_T0;
            ST_PAUSE: begin
                bus.running = 1'b1;
                if (bus.step || !bus.step_mode) w_next = ST_T0;
            end
            ST_T0: begin
                bus.running    = 1'b1;
                bus.ctl_mar_pc = 1'b1;
                w_next         = ST_T1;
            end
            ST_T1, ST_T4: begin
                bus.running    = 1'b1;
                bus.t_state    = (r_state == ST_T1) ? 3'd1 : 3'd4;
                bus.ctl_mem_rd = 1'b1;
                // Ack beats the timeout when both land in the same cycle.
                if (w_done) begin
                    bus.ctl_mbr_ld = 1'b1;
                    bus.ctl_pc_inc = 1'b1;
                    w_next = (r_state == ST_T1) ? ST_T2 : ST_T5;
                end else if (w_tmo) begin
                    w_next = ST_ERR;
                end
            end
            ST_T2: begin
                bus.running   = 1'b1;
                bus.t_state   = 3'd2;
                bus.ctl_ir_ld = 1'b1;
                w_next        = ST_T3;
            end
            ST_T3: begin
                bus.running = 1'b1;
                bus.t_state = 3'd3;
                case (bus.ir_op)
                    OP_NOP: w_next = w_end;
                    OP_MVR: begin
                        bus.ctl_a_r = 1'b1;
                        w_next      = w_end;
                    end
                    OP_HLT: w_next = ST_HALT;
                    OP_LDA: begin
                        bus.ctl_mar_pc = 1'b1;
                        w_next         = ST_T4;
                    end
                    default: w_next = ST_T3;
                endcase
            end
            ST_T5: begin
                bus.running     = 1'b1;
                bus.t_state     = 3'd5;
                bus.ctl_mar_mbr = 1'b1;
                w_next          = ST_T6;
            end
            ST_T6: begin
                bus.running    = 1'b1;
                bus.t_state    = 3'd6;
                bus.ctl_mem_rd = 1'b1;
                if (w_done) begin
                    bus.ctl_mbr_ld = 1'b1;
                    w_next         = ST_T7;
                end else if (w_tmo) begin
                    w_next = ST_ERR;
                end
            end
            ST_T7: begin
                bus.running   = 1'b1;
                bus.t_state   = 3'd7;
                bus.ctl_a_mbr = 1'b1;
                w_next        = w_end;
            end
            ST_HALT: begin
                bus.halted = 1'b1;
                if (bus.start) w_next = ST_T0;
            end
            ST_ERR: bus.mem_err = 1'b1;
            default: w_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mano_sequencer.sv
// Scoreboard bench: per-cycle directed expectations checked by a monitor.
module tb_mano_sequencer;
    import mano_sequencer_pkg::*;

    localparam logic [7:0] C_MARPC  = 8'h80;
    localparam logic [7:0] C_MARMBR = 8'h40;
    localparam logic [7:0] C_PCINC  = 8'h20;
    localparam logic [7:0] C_RD     = 8'h10;
    localparam logic [7:0] C_MBRLD  = 8'h08;
    localparam logic [7:0] C_IRLD   = 8'h04;
    localparam logic [7:0] C_AMBR   = 8'h02;
    localparam logic [7:0] C_AR     = 8'h01;
    localparam logic [7:0] C_FETCH  = C_RD | C_MBRLD | C_PCINC;
    localparam logic [2:0] RUN  = 3'b100;
    localparam logic [2:0] HLT  = 3'b010;
    localparam logic [2:0] ERR  = 3'b001;
    localparam logic [2:0] NONE = 3'b000;

    typedef struct {
        string       nm;
        logic [13:0] v;
    } exp_t;

    logic SysClk;
    logic rst_n;
    int   compared;
    int   mismatched;
    exp_t q[$];

    mano_sequencer_if bus();

    mano_sequencer #(.MEM_TIMEOUT(15)) dut (
        .SysClk(SysClk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial SysClk = 1'b0;
    always #5 SysClk = ~SysClk;

    // in = {rst_n, start, step_mode, step, mem_ack}; f = {running, halted, mem_err}
    task automatic cy(input string nm, input logic [4:0] in,
                      input logic [1:0] op, input logic [7:0] c,
                      input logic [2:0] t, input logic [2:0] f);
        exp_t e;
        @(posedge SysClk);
        #1;
        {rst_n, bus.start, bus.step_mode, bus.step, bus.mem_ack} = in;
        bus.ir_op = op;
        e.nm = nm;
        e.v  = {c, t, f};
        q.push_back(e);
    endtask

    always @(negedge SysClk) begin
        exp_t        e;
        logic [13:0] act;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {bus.ctl_mar_pc, bus.ctl_mar_mbr, bus.ctl_pc_inc,
                   bus.ctl_mem_rd, bus.ctl_mbr_ld, bus.ctl_ir_ld,
                   bus.ctl_a_mbr, bus.ctl_a_r, bus.t_state,
                   bus.running, bus.halted, bus.mem_err};
            compared++;
            if (act !== e.v) begin
                mismatched++;
                $display("FAIL %s: got ctl=%b t=%0d rhe=%b, want ctl=%b t=%0d rhe=%b",
                         e.nm, act[13:6], act[5:3], act[2:0],
                         e.v[13:6], e.v[5:3], e.v[2:0]);
            end
        end
    end

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.step_mode = 1'b0;
        bus.step      = 1'b0;
        bus.ir_op     = OP_NOP;
        bus.mem_ack   = 1'b0;

        cy("rst",      5'b00000, OP_NOP, 8'h00, 3'd0, NONE);
        cy("idle",     5'b11001, OP_MVR, 8'h00, 3'd0, NONE);
        cy("mvr_t0",   5'b10001, OP_MVR, C_MARPC, 3'd0, RUN);
        cy("mvr_t1",   5'b10001, OP_MVR, C_FETCH, 3'd1, RUN);
        cy("mvr_t2",   5'b10001, OP_MVR, C_IRLD, 3'd2, RUN);
        cy("mvr_t3",   5'b10001, OP_MVR, C_AR, 3'd3, RUN);
        cy("mvr_back", 5'b10000, OP_LDA, C_MARPC, 3'd0, RUN);

        for (int i = 0; i < 3; i++)
            cy("lda_t1w", 5'b10000, OP_LDA, C_RD, 3'd1, RUN);
        cy("lda_t1a",  5'b10001, OP_LDA, C_FETCH, 3'd1, RUN);
        cy("lda_t2",   5'b10000, OP_LDA, C_IRLD, 3'd2, RUN);
        cy("lda_t3",   5'b10000, OP_LDA, C_MARPC, 3'd3, RUN);
        for (int i = 0; i < 3; i++)
            cy("lda_t4w", 5'b10000, OP_LDA, C_RD, 3'd4, RUN);
        cy("lda_t4a",  5'b10001, OP_LDA, C_FETCH, 3'd4, RUN);
        cy("lda_t5",   5'b10000, OP_LDA, C_MARMBR, 3'd5, RUN);
        for (int i = 0; i < 3; i++)
            cy("lda_t6w", 5'b10000, OP_LDA, C_RD, 3'd6, RUN);
        cy("lda_t6a",  5'b10001, OP_LDA, C_RD | C_MBRLD, 3'd6, RUN);
        cy("lda_t7",   5'b10100, OP_NOP, C_AMBR, 3'd7, RUN);

        for (int i = 0; i < 10; i++)
            cy("pause", (i < 3) ? 5'b11100 : 5'b10100, OP_NOP, 8'h00, 3'd0, RUN);
        cy("pause_stp", 5'b10110, OP_NOP, 8'h00, 3'd0, RUN);
        cy("nop_t0",   5'b10101, OP_NOP, C_MARPC, 3'd0, RUN);
        cy("nop_t1",   5'b10101, OP_NOP, C_FETCH, 3'd1, RUN);
        cy("nop_t2",   5'b10101, OP_NOP, C_IRLD, 3'd2, RUN);
        cy("nop_t3",   5'b10101, OP_NOP, 8'h00, 3'd3, RUN);
        cy("pause2",   5'b10101, OP_NOP, 8'h00, 3'd0, RUN);
        cy("pause3",   5'b10101, OP_NOP, 8'h00, 3'd0, RUN);
        cy("pause_sm0", 5'b10001, OP_HLT, 8'h00, 3'd0, RUN);

        cy("hlt_t0",   5'b10001, OP_HLT, C_MARPC, 3'd0, RUN);
        cy("hlt_t1",   5'b10001, OP_HLT, C_FETCH, 3'd1, RUN);
        cy("hlt_t2",   5'b10001, OP_HLT, C_IRLD, 3'd2, RUN);
        cy("hlt_t3",   5'b10001, OP_HLT, 8'h00, 3'd3, RUN);
        cy("halt",     5'b10001, OP_HLT, 8'h00, 3'd0, HLT);
        cy("halt",     5'b10001, OP_HLT, 8'h00, 3'd0, HLT);
        cy("halt_go",  5'b11000, OP_MVR, 8'h00, 3'd0, HLT);
        cy("res_t0",   5'b10000, OP_MVR, C_MARPC, 3'd0, RUN);

        // Ack on the 15th wait cycle coincides with the timeout point.
        for (int i = 0; i < 14; i++)
            cy("late_t1w", 5'b10000, OP_MVR, C_RD, 3'd1, RUN);
        cy("late_t1a", 5'b10001, OP_MVR, C_FETCH, 3'd1, RUN);
        cy("late_t2",  5'b10000, OP_MVR, C_IRLD, 3'd2, RUN);
        cy("late_t3",  5'b10000, OP_MVR, C_AR, 3'd3, RUN);
        cy("tmo_t0",   5'b10000, OP_MVR, C_MARPC, 3'd0, RUN);
        for (int i = 0; i < 15; i++)
            cy("tmo_t1w", 5'b10000, OP_MVR, C_RD, 3'd1, RUN);
        cy("err",      5'b10000, OP_MVR, 8'h00, 3'd0, ERR);
        cy("err_start", 5'b11000, OP_MVR, 8'h00, 3'd0, ERR);
        cy("err_start", 5'b11001, OP_MVR, 8'h00, 3'd0, ERR);
        cy("err_rst",  5'b00000, OP_LDA, 8'h00, 3'd0, NONE);

        cy("idle2",    5'b11001, OP_LDA, 8'h00, 3'd0, NONE);
        cy("r_t0",     5'b10001, OP_LDA, C_MARPC, 3'd0, RUN);
        cy("r_t1",     5'b10001, OP_LDA, C_FETCH, 3'd1, RUN);
        cy("r_t2",     5'b10001, OP_LDA, C_IRLD, 3'd2, RUN);
        cy("r_t3",     5'b10001, OP_LDA, C_MARPC, 3'd3, RUN);
        cy("r_t4",     5'b10001, OP_LDA, C_FETCH, 3'd4, RUN);
        cy("t5_rst",   5'b00001, OP_LDA, 8'h00, 3'd0, NONE);
        cy("idle3",    5'b10001, OP_LDA, 8'h00, 3'd0, NONE);
        cy("idle3",    5'b10001, OP_LDA, 8'h00, 3'd0, NONE);
        cy("idle_go",  5'b11001, OP_LDA, 8'h00, 3'd0, NONE);
        cy("go_t0",    5'b10001, OP_LDA, C_MARPC, 3'd0, RUN);

        for (int i = 0; i < 4 && q.size() > 0; i++)
            @(negedge SysClk);
        #1;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
